// File: rtl/id_ex_stage_if.sv
// Bundle of the ID->EX stage signals: decode input, register-file read port,
// writeback snoop port and the EX-side output register.
interface id_ex_stage_if #(
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic [31:0]       in_pc;
  logic [CTRL_W-1:0] in_ctrl;

  logic [4:0]        Rreg1;
  logic [4:0]        Rreg2;
  logic [31:0]       Read1;
  logic [31:0]       Read2;

  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;

  logic              flush;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_rs1_val;
  logic [31:0]       out_rs2_val;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [31:0]       out_imm;
  logic [31:0]       out_pc;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_pc, in_ctrl,
    input  Read1, Read2, wb_we, wb_rd, wb_data, flush, out_ready,
    output in_ready, Rreg1, Rreg2,
    output out_valid, out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd,
    output out_imm, out_pc, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_pc, in_ctrl,
    output Read1, Read2, wb_we, wb_rd, wb_data, flush, out_ready,
    input  in_ready, Rreg1, Rreg2,
    input  out_valid, out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd,
    input  out_imm, out_pc, out_ctrl
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX operand-fetch register with writeback bypass/snoop and flush; 1-cycle latency,
// single entry (in_ready = !out_valid || out_ready). LOAD_USE_STALL_EN adds a load-use bubble.
module id_ex_stage #(
  parameter int CTRL_W   = 16,
  parameter int LOAD_BIT = 0
) (
  input  logic         CLK,
  input  logic         RST_N,
  id_ex_stage_if.slave bus
);

  if (LOAD_BIT < 0 || LOAD_BIT >= CTRL_W) begin : g_bad_load_bit
    $error("id_ex_stage: LOAD_BIT outside ctrl bundle");
  end

  logic              r_valid;
  logic [31:0]       r_rs1_val;
  logic [31:0]       r_rs2_val;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [31:0]       r_imm;
  logic [31:0]       r_pc;
  logic [CTRL_W-1:0] r_ctrl;

  logic        w_wb_live;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_hazard;
  logic        w_in_ready;
  logic        w_load;
  logic        w_hold;

  // x0 never forwards: the register file already returns zero for it
  assign w_wb_live = bus.wb_we && (bus.wb_rd != 5'd0);
  assign w_op1     = (w_wb_live && bus.wb_rd == bus.in_rs1) ? bus.wb_data : bus.Read1;
  assign w_op2     = (w_wb_live && bus.wb_rd == bus.in_rs2) ? bus.wb_data : bus.Read2;

`ifdef LOAD_USE_STALL_EN
  assign w_hazard = bus.in_valid && r_valid && r_ctrl[LOAD_BIT] && (r_rd != 5'd0) &&
                    ((bus.in_rs1 == r_rd) || (bus.in_rs2 == r_rd));
`else
  assign w_hazard = 1'b0;
`endif

  assign w_in_ready = (!r_valid || bus.out_ready) && !w_hazard;
  assign w_load     = bus.in_valid && w_in_ready && !bus.flush;
  assign w_hold     = r_valid && !bus.out_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid   <= 1'b0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_ctrl    <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_rs1_val <= w_op1;
      r_rs2_val <= w_op2;
      r_rs1     <= bus.in_rs1;
      r_rs2     <= bus.in_rs2;
      r_rd      <= bus.in_rd;
      r_imm     <= bus.in_imm;
      r_pc      <= bus.in_pc;
      r_ctrl    <= bus.in_ctrl;
    end else if (w_hold) begin
      // Keep held operands current while EX is not taking them
      if (w_wb_live && bus.wb_rd == r_rs1) r_rs1_val <= bus.wb_data;
      if (w_wb_live && bus.wb_rd == r_rs2) r_rs2_val <= bus.wb_data;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.Rreg1       = bus.in_rs1;
  assign bus.Rreg2       = bus.in_rs2;
  assign bus.out_valid   = r_valid;
  assign bus.out_rs1_val = r_rs1_val;
  assign bus.out_rs2_val = r_rs2_val;
  assign bus.out_rs1     = r_rs1;
  assign bus.out_rs2     = r_rs2;
  assign bus.out_rd      = r_rd;
  assign bus.out_imm     = r_imm;
  assign bus.out_pc      = r_pc;
  assign bus.out_ctrl    = r_ctrl;

endmodule
